// File: rtl/sample_iter_if.sv
// sample_iter_if: triangle/box input bundle and sample output bundle of the sample iterator.
interface sample_iter_if #(
  parameter int SIGFIG = 24,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
);
  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S;
  logic [COLORS-1:0][SIGFIG-1:0]          color_R13U;
  logic [1:0][1:0][SIGFIG-1:0]            box_R13S;
  logic                                   validTri_R13H;
  logic [3:0]                             subSample_RnnnnU;
  logic                                   halt_RnnnnH;
  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S;
  logic [COLORS-1:0][SIGFIG-1:0]          color_R14U;
  logic [1:0][SIGFIG-1:0]                 sample_R14S;
  logic                                   validSamp_R14H;
  logic                                   triDone_R14H;
  modport slave (
    input  tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnnnU,
    output halt_RnnnnH, tri_R14S, color_R14U, sample_R14S, validSamp_R14H, triDone_R14H
  );
  modport master (
    output tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnnnU,
    input  halt_RnnnnH, tri_R14S, color_R14U, sample_R14S, validSamp_R14H, triDone_R14H
  );
endinterface

// File: rtl/sample_iter.sv
// sample_iter: walks the sample grid of each bounding box in raster order, one sample per cycle.
module sample_iter #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
) (
  input logic         clk,
  input logic         rst_n,
  sample_iter_if.slave bus
);
  typedef enum logic {WAIT, TEST} state_t;
  localparam logic [SIGFIG-1:0] UNIT = SIGFIG'(1 << RADIX);
  state_t                                 state_q, state_d;
  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_q, tri_d;
  logic [COLORS-1:0][SIGFIG-1:0]          color_q, color_d;
  logic [1:0][SIGFIG-1:0]                 ll_q, ll_d, ur_q, ur_d, samp_q, samp_d;
  logic [SIGFIG-1:0]                      step_q, step_d, step_in;
  logic signed [SIGFIG:0]                 nx, ny;
  logic                                   x_ok, y_ok, last, box_ok;
  // anything that is not a clean one-hot falls back to one sample per pixel
  assign step_in = bus.subSample_RnnnnU == 4'b0100 ? UNIT >> 1 :
                   bus.subSample_RnnnnU == 4'b0010 ? UNIT >> 2 :
                   bus.subSample_RnnnnU == 4'b0001 ? UNIT >> 3 : UNIT;
  assign box_ok = $signed(bus.box_R13S[1][0]) >= $signed(bus.box_R13S[0][0]) &&
                  $signed(bus.box_R13S[1][1]) >= $signed(bus.box_R13S[0][1]);
  // one extra bit so stepping past the largest coordinate cannot wrap
  assign nx   = $signed({samp_q[0][SIGFIG-1], samp_q[0]}) + $signed({1'b0, step_q});
  assign ny   = $signed({samp_q[1][SIGFIG-1], samp_q[1]}) + $signed({1'b0, step_q});
  assign x_ok = nx <= $signed({ur_q[0][SIGFIG-1], ur_q[0]});
  assign y_ok = ny <= $signed({ur_q[1][SIGFIG-1], ur_q[1]});
  assign last = !x_ok && !y_ok;
  always_comb begin
    state_d = state_q;
    tri_d   = tri_q;
    color_d = color_q;
    ll_d    = ll_q;
    ur_d    = ur_q;
    step_d  = step_q;
    samp_d  = samp_q;
    if (state_q == WAIT) begin
      if (bus.validTri_R13H) begin
        tri_d   = bus.tri_R13S;
        color_d = bus.color_R13U;
        ll_d    = bus.box_R13S[0];
        ur_d    = bus.box_R13S[1];
        step_d  = step_in;
        samp_d  = box_ok ? bus.box_R13S[0] : samp_q;
        state_d = box_ok ? TEST : WAIT;
      end
    end else begin
      samp_d[0] = x_ok ? nx[SIGFIG-1:0] : y_ok ? ll_q[0] : samp_q[0];
      samp_d[1] = !x_ok && y_ok ? ny[SIGFIG-1:0] : samp_q[1];
      state_d   = last ? WAIT : TEST;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT;
      tri_q   <= '0;
      color_q <= '0;
      ll_q    <= '0;
      ur_q    <= '0;
      step_q  <= '0;
      samp_q  <= '0;
    end else begin
      state_q <= state_d;
      tri_q   <= tri_d;
      color_q <= color_d;
      ll_q    <= ll_d;
      ur_q    <= ur_d;
      step_q  <= step_d;
      samp_q  <= samp_d;
    end
  end
  assign bus.halt_RnnnnH    = state_q == TEST;
  assign bus.validSamp_R14H = state_q == TEST;
  assign bus.triDone_R14H   = state_q == TEST && last;
  assign bus.tri_R14S       = tri_q;
  assign bus.color_R14U     = color_q;
  assign bus.sample_R14S    = samp_q;
endmodule

// File: tb/tb_sample_iter.sv
// tb_sample_iter: scoreboard bench for sample_iter; expected samples are queued when a box is driven.
module tb_sample_iter;
  typedef logic [2:0][2:0][23:0] tri_t;
  typedef logic [2:0][23:0] col_t;
  typedef struct {int x; int y; logic done;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  exp_t q[$];
  tri_t exp_tri;
  sample_iter_if bus();
  sample_iter dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic tri_t mk_tri(input int seed);
    tri_t r;
    for (int v = 0; v < 3; v++)
      for (int a = 0; a < 3; a++) r[v][a] = 24'(seed * 16 + v * 3 + a);
    return r;
  endfunction
  function automatic col_t mk_col(input int seed);
    col_t r;
    for (int c = 0; c < 3; c++) r[c] = 24'(seed * 7 + c + 100);
    return r;
  endfunction
  task automatic push_box(input int llx, input int lly, input int urx, input int ury, input int step);
    for (int y = lly; y <= ury; y += step)
      for (int x = llx; x <= urx; x += step) begin
        exp_t e;
        e.x = x;
        e.y = y;
        e.done = (x + step > urx) && (y + step > ury);
        q.push_back(e);
      end
  endtask
  task automatic drive(input int llx, input int lly, input int urx, input int ury,
                       input logic [3:0] ss, input int seed);
    bus.tri_R13S = mk_tri(seed);
    bus.color_R13U = mk_col(seed);
    bus.box_R13S[0][0] = 24'(llx);
    bus.box_R13S[0][1] = 24'(lly);
    bus.box_R13S[1][0] = 24'(urx);
    bus.box_R13S[1][1] = 24'(ury);
    bus.subSample_RnnnnU = ss;
    bus.validTri_R13H = 1'b1;
  endtask
  task automatic send(input int llx, input int lly, input int urx, input int ury,
                      input logic [3:0] ss, input int seed);
    drive(llx, lly, urx, ury, ss, seed);
    exp_tri = mk_tri(seed);
    @(posedge clk);
    #1 bus.validTri_R13H = 1'b0;
  endtask
  task automatic collect(input string name, input int budget, output int halt_cycles);
    int n = 0;
    halt_cycles = 0;
    forever begin
      @(negedge clk);
      n++;
      if (bus.halt_RnnnnH) halt_cycles++;
      if (bus.validSamp_R14H) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL %s extra_sample got=(%0d,%0d) expected none", name,
                   $signed(bus.sample_R14S[0]), $signed(bus.sample_R14S[1]));
        end else begin
          exp_t e = q.pop_front();
          if (bus.sample_R14S[0] !== 24'(e.x) || bus.sample_R14S[1] !== 24'(e.y) ||
              bus.triDone_R14H !== e.done || bus.tri_R14S !== exp_tri) begin
            failures++;
            $display("FAIL %s sample got=(%0d,%0d) done=%b tri00=%0d expected=(%0d,%0d) done=%b tri00=%0d",
                     name, $signed(bus.sample_R14S[0]), $signed(bus.sample_R14S[1]), bus.triDone_R14H,
                     bus.tri_R14S[0][0], e.x, e.y, e.done, exp_tri[0][0]);
          end
        end
      end else if (q.size() == 0) break;
      if (n >= budget) begin
        checks++;
        failures++;
        $display("FAIL %s timeout after %0d cycles, %0d samples missing", name, n, q.size());
        q.delete();
        break;
      end
    end
    checks++;
    if (bus.halt_RnnnnH !== 1'b0 || bus.triDone_R14H !== 1'b0) begin
      failures++;
      $display("FAIL %s idle got halt=%b done=%b expected halt=0 done=0", name,
               bus.halt_RnnnnH, bus.triDone_R14H);
    end
  endtask
  task automatic test_reset();
    bus.validTri_R13H = 1'b0;
    bus.subSample_RnnnnU = 4'b1000;
    bus.tri_R13S = '0;
    bus.color_R13U = '0;
    bus.box_R13S = '0;
    rst_n = 1'b0;
    #12;
    checks++;
    if ({bus.halt_RnnnnH, bus.validSamp_R14H, bus.triDone_R14H} !== 3'b000 ||
        bus.sample_R14S !== '0 || bus.tri_R14S !== '0 || bus.color_R14U !== '0) begin
      failures++;
      $display("FAIL reset got halt=%b valid=%b done=%b sample=%h expected all zero",
               bus.halt_RnnnnH, bus.validSamp_R14H, bus.triDone_R14H, bus.sample_R14S);
    end
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.validSamp_R14H !== 1'b0 || bus.halt_RnnnnH !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got valid=%b halt=%b expected 0 0", bus.validSamp_R14H, bus.halt_RnnnnH);
    end
  endtask
  task automatic test_1spp();
    int h;
    push_box(0, 0, 1024, 1024, 1024);
    send(0, 0, 1024, 1024, 4'b1000, 1);
    collect("1spp", 20, h);
    checks++;
    if (h !== 4) begin
      failures++;
      $display("FAIL 1spp_halt_cycles got=%0d expected=4", h);
    end
    checks++;
    if (bus.color_R14U !== mk_col(1)) begin
      failures++;
      $display("FAIL 1spp_color got=%h expected=%h", bus.color_R14U, mk_col(1));
    end
  endtask
  task automatic test_subsample();
    int h;
    push_box(0, 0, 1024, 1024, 512);
    send(0, 0, 1024, 1024, 4'b0100, 2);
    collect("4spp", 30, h);
    push_box(0, 0, 256, 128, 128);
    send(0, 0, 256, 128, 4'b0001, 3);
    collect("64spp", 30, h);
    push_box(0, 0, 1024, 0, 1024);
    send(0, 0, 1024, 0, 4'b0110, 4);
    collect("bad_onehot", 30, h);
    push_box(-1024, -1024, 0, 0, 512);
    send(-1024, -1024, 0, 0, 4'b0100, 5);
    collect("negative_box", 30, h);
  endtask
  task automatic test_degenerate();
    int h;
    push_box(2048, 3072, 2048, 3072, 1024);
    send(2048, 3072, 2048, 3072, 4'b1000, 6);
    collect("degenerate", 10, h);
    checks++;
    if (h !== 1) begin
      failures++;
      $display("FAIL degenerate_halt_cycles got=%0d expected=1", h);
    end
  endtask
  task automatic test_inverted();
    int h;
    send(1024, 0, 0, 0, 4'b1000, 7);
    @(negedge clk);
    checks++;
    if (bus.validSamp_R14H !== 1'b0 || bus.halt_RnnnnH !== 1'b0) begin
      failures++;
      $display("FAIL inverted got valid=%b halt=%b expected 0 0", bus.validSamp_R14H, bus.halt_RnnnnH);
    end
    push_box(0, 0, 1024, 1024, 1024);
    send(0, 0, 1024, 1024, 4'b1000, 8);
    collect("after_inverted", 20, h);
  endtask
  task automatic test_back_to_back();
    int h;
    push_box(0, 0, 1024, 1024, 512);
    send(0, 0, 1024, 1024, 4'b0100, 9);
    drive(2048, 3072, 2048, 3072, 4'b1000, 10);
    collect("ignored_while_halt", 30, h);
    checks++;
    if (bus.tri_R14S !== mk_tri(9)) begin
      failures++;
      $display("FAIL tri_held got tri00=%0d expected tri00=%0d", bus.tri_R14S[0][0], mk_tri(9) & 24'hffffff);
    end
    push_box(2048, 3072, 2048, 3072, 1024);
    exp_tri = mk_tri(10);
    @(posedge clk);
    #1 bus.validTri_R13H = 1'b0;
    collect("back_to_back", 10, h);
  endtask
  task automatic test_reset_mid();
    logic bad = 1'b0;
    send(0, 0, 768, 768, 4'b0010, 11);
    repeat (5) @(negedge clk);
    checks++;
    if (bus.validSamp_R14H !== 1'b1 || bus.triDone_R14H !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_walking got valid=%b done=%b expected 1 0", bus.validSamp_R14H, bus.triDone_R14H);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.halt_RnnnnH, bus.validSamp_R14H, bus.triDone_R14H} !== 3'b000 ||
        bus.sample_R14S !== '0 || bus.tri_R14S !== '0) begin
      failures++;
      $display("FAIL reset_mid got halt=%b valid=%b done=%b sample=%h expected all zero",
               bus.halt_RnnnnH, bus.validSamp_R14H, bus.triDone_R14H, bus.sample_R14S);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus.validSamp_R14H !== 1'b0 || bus.triDone_R14H !== 1'b0 || bus.halt_RnnnnH !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL reset_mid_resume got activity after reset expected idle WAIT");
    end
  endtask
  initial begin
    test_reset();
    test_1spp();
    test_subsample();
    test_degenerate();
    test_inverted();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
